data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised data memory for the processor datapath. It replaces the fixed 8×256 array with configurable width and depth, and adds:
- a valid/ready request port with a registered response;
- a power-on clear sequence;
- an out-of-range error flag.

An asynchronous debug read port feeds the board display.

## Interface
Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 8, address width in bits
- DEPTH, 2**ADDR_W, number of implemented words (1..2**ADDR_W)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  0 = read, 1 = write
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data (for a write, the data written)
- rsp_err  out  1  the request addressed a location ≥ DEPTH
- dbg_addr  in  ADDR_W  display read address
- dbg_data  out  DATA_W  combinational contents at dbg_addr (0 if dbg_addr ≥ DEPTH)
- init_busy  out  1  clear sequence in progress

## Operation
- States: INIT and READY.
  - Reset forces INIT with clear counter = 0.
  - In INIT, each cycle writes 0 to mem[counter] and increments the counter.
  - After the write of address DEPTH-1, the next state is READY.
- init_busy = (state == INIT).
- req_ready = (state == READY) && (!rsp_valid || rsp_ready).
- A request is accepted when req_valid && req_ready.
- The array is not reset directly. Contents are defined only after INIT completes.

Accepted read:
- rsp_rdata = mem[req_addr], sampled at the accept edge.
- rsp_err = 0.

Accepted write:
- mem[req_addr] = req_wdata at the accept edge.
- rsp_rdata = req_wdata, rsp_err = 0.

Out-of-range request (req_addr ≥ DEPTH):
- No array write occurs.
- rsp_rdata = 0, rsp_err = 1.

Response register:
- rsp_valid is set on accept.
- rsp_valid is cleared on rsp_valid && rsp_ready with no new accept.
- If a new accept coincides with a response handshake, the response register is reloaded and rsp_valid stays 1.
- While rsp_valid && !rsp_ready, rsp_* hold stable and req_ready = 0.

Debug port:
- dbg_data reads the array asynchronously and is independent of the handshake.
- A write becomes visible on dbg_data after the accept edge.
- During INIT, dbg_data returns the current array contents.

Reset:
- rst_n low mid-operation aborts any pending response (rsp_valid drops immediately) and restarts INIT from address 0.
- Words written before the reset are cleared again by the new INIT sweep.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, init_busy 1.
- INIT takes exactly DEPTH rising edges after rst_n deasserts. req_ready first rises after edge DEPTH.
- Latency: 1 cycle from accept to rsp_valid.
- Throughput: 1 request per cycle while rsp_ready = 1.
- Read after write to the same address on consecutive accepts returns the new data.
- dbg_data is a combinational path from dbg_addr and the array; it has no clock latency.

## Structure
- data_mem_pkg holds:
  - the state typedef (ST_INIT, ST_READY);
  - the op constants OP_READ = 1'b0 and OP_WRITE = 1'b1.
- Sub-module dp_ram(DATA_W, DEPTH) is the storage. It has one synchronous write port and two asynchronous read ports: request and debug.
- data_mem_ctrl holds the FSM, clear counter, range check and response register. The write-port mux between the INIT clear and request writes lives in data_mem_ctrl.

## Test plan
- Reset release with DEPTH=256 → init_busy high for exactly 256 edges, req_ready rises after edge 256, and dbg_data = 0 for every dbg_addr.
- Write 0xA5 to address 0x10, then read 0x10 on the next cycle with rsp_ready = 1 → two responses, rsp_rdata = 0xA5 both times, rsp_err = 0. dbg_addr = 0x10 shows 0xA5 after the write edge.
- DEPTH=200: write 0x3C to address 200, then read address 200 → rsp_err = 1 and rsp_rdata = 0 for both. Address 199 is unchanged.
- Backpressure: hold rsp_ready = 0 after a read of 0x05 → rsp_valid stays 1, rsp_rdata holds, and req_ready = 0. Raising rsp_ready with req_valid high completes the handshake and accepts the next request in the same cycle.
- Streaming: 8 back-to-back writes, then 8 reads, with rsp_ready tied high → one response per cycle, in order, with matching data.
- Assert rst_n low while rsp_valid = 1 after writing 0xFF to address 3 → rsp_valid drops asynchronously, INIT reruns, and a later read of address 3 returns 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types for the data memory controller.
// Holds the controller state encoding and the request opcode values.
package data_mem_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/data_mem_ctrl_dp_ram.sv
// dp_ram: word storage with one synchronous write port and two
// asynchronous read ports (request side and debug side).
// Ports:
//   clk                : write clock
//   we_i/waddr_i/wdata_i : write port, applied on the rising edge
//   raddr_a_i/rdata_a_o  : request read port, combinational
//   raddr_b_i/rdata_b_o  : debug read port, combinational
module dp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [IDX_W-1:0]  raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    // No reset on the array; the controller's clear sweep defines contents.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: parametrised data memory with valid/ready request port,
// registered response, power-on clear sweep and out-of-range error flag.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_ready        : request handshake
//   req_write/req_addr/req_wdata : request payload
//   rsp_valid/rsp_ready        : response handshake
//   rsp_rdata/rsp_err          : response payload
//   dbg_addr/dbg_data          : combinational display read port
//   init_busy                  : clear sweep in progress
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              init_busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e            state_q;
    logic [IDX_W-1:0]  clr_cnt_q;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic              req_in_range;
    logic              dbg_in_range;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] ram_dbg;

    assign req_in_range = {1'b0, req_addr} < DEPTH_L;
    assign dbg_in_range = {1'b0, dbg_addr} < DEPTH_L;

    assign init_busy = (state_q == ST_INIT);
    assign req_ready = (state_q == ST_READY)
                    && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    // Write port: clear sweep owns it during INIT, requests afterwards.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_cnt_q;
        ram_wdata = '0;
        if (state_q == ST_INIT) begin
            ram_we = 1'b1;
        end else begin
            ram_we    = accept && req_in_range
                     && (req_write == OP_WRITE);
            ram_waddr = req_addr[IDX_W-1:0];
            ram_wdata = req_wdata;
        end
    end

    dp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk       (clk),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata),
        .raddr_a_i (req_addr[IDX_W-1:0]),
        .rdata_a_o (ram_rdata),
        .raddr_b_i (dbg_addr[IDX_W-1:0]),
        .rdata_b_o (ram_dbg)
    );

    assign dbg_data = dbg_in_range ? ram_dbg : '0;

    // Response register: load on accept, drop on handshake without
    // a new accept, otherwise hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            if (!req_in_range) begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
            end else begin
                rsp_err_d = 1'b0;
                unique case (req_write)
                    OP_READ:  rsp_rdata_d = ram_rdata;
                    OP_WRITE: rsp_rdata_d = req_wdata;
                    default:  rsp_rdata_d = ram_rdata;
                endcase
            end
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            unique case (state_q)
                ST_INIT: begin
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q <= ST_READY;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + IDX_W'(1);
                    end
                end
                ST_READY: begin
                    state_q <= ST_READY;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed bench for data_mem_ctrl.
// Two instances (DEPTH 256 and 200) share one stimulus stream.
module tb_data_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_ready;
    logic [7:0] dbg_addr;

    logic       req_ready_a, rsp_valid_a, rsp_err_a, init_busy_a;
    logic [7:0] rsp_rdata_a, dbg_data_a;
    logic       req_ready_b, rsp_valid_b, rsp_err_b, init_busy_b;
    logic [7:0] rsp_rdata_b, dbg_data_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready_a),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid_a),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata_a),
        .rsp_err   (rsp_err_a),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data_a),
        .init_busy (init_busy_a)
    );

    data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready_b),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid_b),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata_b),
        .rsp_err   (rsp_err_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data_b),
        .init_busy (init_busy_b)
    );

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Counts edges after reset release until each instance leaves INIT.
    task automatic wait_init(output int ba, output int bb,
                             output int ra);
        ba = 0;
        bb = 0;
        ra = 0;
        for (int e = 1; e <= 300; e++) begin
            @(posedge clk);
            #1;
            if (ba == 0 && !init_busy_a) ba = e;
            if (bb == 0 && !init_busy_b) bb = e;
            if (ra == 0 && req_ready_a) ra = e;
            if (ba != 0 && bb != 0 && ra != 0) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ba, bb, ra;
        int errs_a, errs_b;

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        dbg_addr  = '0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);

        vecs[0] = '{wr: 1'b1, addr: 8'h10, wdata: 8'hA5, exp: 8'hA5};
        vecs[1] = '{wr: 1'b0, addr: 8'h10, wdata: 8'h00, exp: 8'hA5};
        for (int i = 0; i < 8; i++) begin
            vecs[2+i] = '{wr: 1'b1, addr: 8'(8'h20 + i),
                          wdata: 8'(8'h11 * (i + 1)),
                          exp: 8'(8'h11 * (i + 1))};
            vecs[10+i] = '{wr: 1'b0, addr: 8'(8'h20 + i),
                           wdata: 8'h00,
                           exp: 8'(8'h11 * (i + 1))};
        end

        // Reset values
        #2;
        chk("rst_req_ready", req_ready_a, 0);
        chk("rst_rsp_valid", rsp_valid_a, 0);
        chk("rst_rsp_rdata", rsp_rdata_a, 0);
        chk("rst_rsp_err", rsp_err_a, 0);
        chk("rst_init_busy", init_busy_a, 1);
        chk("rst_init_busy_b", init_busy_b, 1);

        // Clear sweep length
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(ba, bb, ra);
        chk("init_edges_a", ba, 256);
        chk("init_edges_b", bb, 200);
        chk("ready_edge_a", ra, 256);

        errs_a = 0;
        errs_b = 0;
        for (int a = 0; a < 256; a++) begin
            dbg_addr = 8'(a);
            #1;
            if (dbg_data_a !== 8'h00) errs_a++;
            if (dbg_data_b !== 8'h00) errs_b++;
        end
        chk("dbg_clear_a", errs_a, 0);
        chk("dbg_clear_b", errs_b, 0);

        // Table: write/read pair then 8 streamed writes and reads
        tick();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_req_ready", i), req_ready_a, 1);
            tick();
            chk($sformatf("vec%0d_valid", i), rsp_valid_a, 1);
            chk($sformatf("vec%0d_rdata", i), rsp_rdata_a, vecs[i].exp);
            chk($sformatf("vec%0d_err", i), rsp_err_a, 0);
            chk($sformatf("vec%0d_rdata_b", i), rsp_rdata_b,
                vecs[i].exp);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk("stream_drain_valid", rsp_valid_a, 0);
        dbg_addr = 8'h10;
        #1;
        chk("dbg_10", dbg_data_a, 8'hA5);

        // Debug visibility exactly at the write edge
        dbg_addr = 8'h40;
        drive(1'b1, 1'b1, 8'h40, 8'h7E);
        #1;
        chk("dbg_40_before", dbg_data_a, 8'h00);
        tick();
        chk("dbg_40_after", dbg_data_a, 8'h7E);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        tick();

        // Out-of-range on the DEPTH=200 instance
        drive(1'b1, 1'b1, 8'd200, 8'h3C);
        tick();
        chk("oor_wr_err_b", rsp_err_b, 1);
        chk("oor_wr_rdata_b", rsp_rdata_b, 0);
        chk("oor_wr_err_a", rsp_err_a, 0);
        chk("oor_wr_rdata_a", rsp_rdata_a, 8'h3C);
        drive(1'b1, 1'b0, 8'd200, 8'h00);
        tick();
        chk("oor_rd_valid_b", rsp_valid_b, 1);
        chk("oor_rd_err_b", rsp_err_b, 1);
        chk("oor_rd_rdata_b", rsp_rdata_b, 0);
        chk("oor_rd_rdata_a", rsp_rdata_a, 8'h3C);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        dbg_addr = 8'd199;
        #1;
        chk("dbg_199_b", dbg_data_b, 0);
        dbg_addr = 8'd200;
        #1;
        chk("dbg_200_b", dbg_data_b, 0);
        chk("dbg_200_a", dbg_data_a, 8'h3C);
        tick();

        // Backpressure
        drive(1'b1, 1'b1, 8'h05, 8'h5A);
        tick();
        drive(1'b1, 1'b0, 8'h05, 8'h00);
        tick();
        chk("bp_rd_rdata", rsp_rdata_a, 8'h5A);
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h10, 8'h00);
        #1;
        chk("bp_req_ready0", req_ready_a, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_hold%0d_valid", k), rsp_valid_a, 1);
            chk($sformatf("bp_hold%0d_rdata", k), rsp_rdata_a, 8'h5A);
            chk($sformatf("bp_hold%0d_ready", k), req_ready_a, 0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready_a, 1);
        tick();
        chk("bp_next_valid", rsp_valid_a, 1);
        chk("bp_next_rdata", rsp_rdata_a, 8'hA5);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk("bp_drain_valid", rsp_valid_a, 0);

        // Reset while a response is pending
        drive(1'b1, 1'b1, 8'h03, 8'hFF);
        tick();
        rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("mr_pending_valid", rsp_valid_a, 1);
        chk("mr_pending_rdata", rsp_rdata_a, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_valid", rsp_valid_a, 0);
        chk("mr_busy", init_busy_a, 1);
        chk("mr_req_ready", req_ready_a, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        wait_init(ba, bb, ra);
        chk("mr_init_edges_a", ba, 256);
        chk("mr_init_edges_b", bb, 200);
        dbg_addr = 8'h03;
        #1;
        chk("mr_dbg_03", dbg_data_a, 0);
        drive(1'b1, 1'b0, 8'h03, 8'h00);
        tick();
        chk("mr_rd_valid", rsp_valid_a, 1);
        chk("mr_rd_rdata", rsp_rdata_a, 0);
        chk("mr_rd_err", rsp_err_a, 0);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
